// File: rtl/code_rx.sv
// ---------------------------------------------------------------------------
// code_rx -- serial receiver for the single-wire code link (4 kHz, GPIO_1[17])
//
// Recovers 8-bit codes sent by the transmitter board. The line idles high;
// each frame is one low start bit, eight data bits MSB first, and one high
// stop bit, every bit lasting CLKS_PER_BIT cycles of CLOCK_50. The receiver
// re-aligns on every start edge and samples each bit at its midpoint.
//
// Parameters
//   CLKS_PER_BIT  CLOCK_50 cycles per bit (50 MHz / 4 kHz = 12500).
//                 Must be even and at least 8.
//   SYNC_STAGES   flops in the input synchronizer, at least 2.
//
// Ports
//   CLOCK_50    in   system clock, all logic on its rising edge
//   reset_n     in   synchronous active-low reset
//   serial_in   in   asynchronous line from the GPIO pin, idles high
//   code_out    out  [7:0] last correctly framed code (bit 7 = first data bit)
//   code_valid  out  one-cycle pulse when code_out is updated
//   frame_err   out  one-cycle pulse when the stop bit is sampled low
//   busy        out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module code_rx #(
    parameter int CLKS_PER_BIT = 12500,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       serial_in,
    output logic [7:0] code_out,
    output logic       code_valid,
    output logic       frame_err,
    output logic       busy
);

    // Cycle counter only ever has to reach CLKS_PER_BIT - 1.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Start bit is resampled at its middle; every later bit one full period on.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizer and falling-edge detect
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_s;
    logic                   line_prev_q;
    logic                   fall_edge;

    // Synchronizer flops reset to the idle level so that leaving reset on a
    // high line cannot look like a start edge.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of its neighbours (a shift chain
    // written with blocking assignments would collapse into a single flop).
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            sync_q      <= '1;
            line_prev_q <= 1'b1;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], serial_in};
            line_prev_q <= line_s;
        end
    end

    assign line_s    = sync_q[SYNC_STAGES-1];
    assign fall_edge = line_prev_q & ~line_s;

    // -----------------------------------------------------------------------
    // Receive FSM: state register
    // -----------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       code_q,    code_d;
    logic             valid_q,   valid_d;
    logic             err_q,     err_d;
    logic             busy_q,    busy_d;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // -----------------------------------------------------------------------
    // Receive FSM: next state and datapath
    // -----------------------------------------------------------------------
    // NOTE: every variable driven here gets a default before the case, so no
    // path leaves one unassigned and no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = cnt_q;
                if (fall_edge) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (cnt_q == HALF_LAST) begin
                    state_d = line_s ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[6:0], line_s};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            S_STOP: begin
                // Returning straight to IDLE keeps a start bit that follows
                // the stop bit immediately within reach of the edge detector.
                if (cnt_q == BIT_LAST) begin
                    if (line_s) begin
                        code_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end

            S_WAIT_HIGH: begin
                // No edge detection here: a break or stuck-low line must go
                // high before a new frame can be recognised.
                cnt_d = cnt_q;
                if (line_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counters restart from zero on every state entry.
        if (state_d != state_q) begin
            cnt_d     = '0;
            bit_idx_d = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_code_rx.sv
// ---------------------------------------------------------------------------
// tb_code_rx -- directed self-checking bench for code_rx
//
// Runs with CLKS_PER_BIT = 16 and SYNC_STAGES = 2. Stimulus is driven on the
// falling clock edge and outputs are observed on the falling edge, half a
// cycle away from the rising edge the DUT uses. A monitor records every
// code_valid / frame_err pulse with the cycle it was seen in.
// ---------------------------------------------------------------------------
module tb_code_rx;

    localparam int CPB = 16;
    localparam int SYN = 2;

    logic       clk;
    logic       reset_n;
    logic       serial_in;
    logic [7:0] code_out;
    logic       code_valid;
    logic       frame_err;
    logic       busy;

    code_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYN)
    ) dut (
        .CLOCK_50  (clk),
        .reset_n   (reset_n),
        .serial_in (serial_in),
        .code_out  (code_out),
        .code_valid(code_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;           // rising edges seen so far
    int tx_start_cyc = 0;  // value of cyc when the last start bit was driven

    int       valid_cnt = 0;
    int       err_cnt   = 0;
    int       overlap   = 0;
    int       stuck     = 0;
    logic     prev_valid = 1'b0;
    logic     prev_err   = 1'b0;
    logic [7:0] rx_code [16];
    int         rx_cyc  [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (code_valid === 1'b1) begin
            valid_cnt++;
            if (valid_cnt < 16) begin
                rx_code[valid_cnt] = code_out;
                rx_cyc[valid_cnt]  = cyc;
            end
        end
        if (frame_err === 1'b1) err_cnt++;
        if (code_valid === 1'b1 && frame_err === 1'b1) overlap++;
        if ((code_valid === 1'b1 && prev_valid) || (frame_err === 1'b1 && prev_err)) stuck++;
        prev_valid = (code_valid === 1'b1);
        prev_err   = (frame_err === 1'b1);
    end

    // -----------------------------------------------------------------------
    // Line drivers (always entered and left on a falling clock edge)
    // -----------------------------------------------------------------------
    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int len);
        serial_in = b;
        repeat (len) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int per);
        tx_start_cyc = cyc;
        send_bit(1'b0, per);
        for (int i = 7; i >= 0; i--) send_bit(data[i], per);
        send_bit(1'b1, per);
    endtask

    // Slow transmitter: bit lengths alternate 17/16 cycles (about 3% long).
    // A constant 17-cycle bit drifts more than half a bit by the stop sample.
    task automatic send_frame_slow(input logic [7:0] data);
        logic b;
        tx_start_cyc = cyc;
        for (int j = 0; j < 10; j++) begin
            if (j == 0)      b = 1'b0;
            else if (j == 9) b = 1'b1;
            else             b = data[8 - j];
            send_bit(b, (j % 2 == 0) ? 17 : 16);
        end
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        int busy_cycles;

        reset_n   = 1'b0;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_code_out",   code_out,   8'h00);
        check("rst_code_valid", code_valid, 1'b0);
        check("rst_frame_err",  frame_err,  1'b0);
        check("rst_busy",       busy,       1'b0);
        reset_n = 1'b1;
        idle(20);

        // Single frame 0xA5. From the first rising edge that samples the low
        // start bit: SYN edges to the edge detector acting, then 8 + 9*16.
        send_frame(8'hA5, CPB);
        idle(20);
        check("a5_valid_cnt", valid_cnt, 1);
        check("a5_code",      rx_code[1], 8'hA5);
        check("a5_latency",   rx_cyc[1] - tx_start_cyc - 1, 154);
        check("a5_no_err",    err_cnt, 0);

        // 5-cycle low glitch: START runs 8 cycles, then falls back to IDLE.
        busy_cycles = 0;
        serial_in   = 1'b0;
        for (int i = 0; i < 45; i++) begin
            if (i == 5) serial_in = 1'b1;
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
        end
        check("glitch_busy_cycles", busy_cycles, 8);
        check("glitch_no_valid",    valid_cnt, 1);
        check("glitch_no_err",      err_cnt, 0);
        check("glitch_code_hold",   code_out, 8'hA5);

        // Back-to-back frames with no idle gap.
        send_frame(8'h3C, CPB);
        send_frame(8'hC3, CPB);
        idle(20);
        check("b2b_valid_cnt", valid_cnt, 3);
        check("b2b_first",     rx_code[2], 8'h3C);
        check("b2b_second",    rx_code[3], 8'hC3);
        check("b2b_spacing",   rx_cyc[3] - rx_cyc[2], 160);

        // 0xFF with the stop bit low and the line held low for 40 cycles.
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(1'b1, CPB);
        send_bit(1'b0, 40);
        check("ferr_busy_while_low", busy, 1'b1);
        check("ferr_err_cnt",        err_cnt, 1);
        check("ferr_no_valid",       valid_cnt, 3);
        idle(10);
        check("ferr_idle_after_high", busy, 1'b0);
        check("ferr_code_hold",       code_out, 8'hC3);

        // Reset for one cycle in the middle of data bit 4 of 0x81.
        send_bit(1'b0, CPB);
        send_bit(1'b1, CPB);
        for (int i = 0; i < 3; i++) send_bit(1'b0, CPB);
        send_bit(1'b0, CPB / 2);
        reset_n   = 1'b0;
        serial_in = 1'b1;
        @(negedge clk);
        check("midrst_code_out", code_out, 8'h00);
        check("midrst_busy",     busy,     1'b0);
        reset_n = 1'b1;
        idle(20);
        check("midrst_no_pulse", valid_cnt, 3);
        send_frame(8'h7E, CPB);
        idle(20);
        check("after_rst_valid_cnt", valid_cnt, 4);
        check("after_rst_code",      rx_code[4], 8'h7E);
        check("after_rst_code_out",  code_out,   8'h7E);

        // Slow transmitter, 0x5A.
        send_frame_slow(8'h5A);
        idle(20);
        check("slow_valid_cnt", valid_cnt, 5);
        check("slow_code",      code_out,  8'h5A);
        check("slow_no_err",    err_cnt,   1);

        // Pulse hygiene across the whole run.
        check("pulses_never_together", overlap, 0);
        check("pulses_single_cycle",   stuck,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
